// File: rtl/win_pkg.sv
// Shared types and defaults for the 3x3 window controller.
// pixel_t is RGB444 {R,G,B}; state_e is the sequencing FSM.
package win_pkg;

  localparam int DEF_IMG_W = 320;
  localparam int DEF_IMG_H = 240;
  localparam int DEF_DW    = 12;

  typedef logic [DEF_DW-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    EOL,
    FLUSH
  } state_e;

endpackage

// File: rtl/line_buffer.sv
// One line of pixel storage: sync write, async read.
// Ports: clk, we/waddr/wdata write port, raddr/rdata read port.
module line_buffer
  import win_pkg::*;
#(
  parameter int W  = DEF_IMG_W,
  parameter int DW = DEF_DW,
  parameter int AW = $clog2(W)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/window3x3_ctrl.sv
// Raster stream -> zero-padded 3x3 windows, one per pixel.
// Ports: clk, reset_n, sof/valid/data in, ready_o, window taps/coords/eof out.
module window3x3_ctrl
  import win_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int DW    = DEF_DW,
  parameter int XW    = $clog2(IMG_W),
  parameter int YOW   = $clog2(IMG_H)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           sof_i,
  input  logic           pix_valid_i,
  input  logic [DW-1:0]  pix_data_i,
  output logic           ready_o,
  output logic           win_valid_o,
  output logic [DW-1:0]  data_00_o,
  output logic [DW-1:0]  data_01_o,
  output logic [DW-1:0]  data_02_o,
  output logic [DW-1:0]  data_10_o,
  output logic [DW-1:0]  data_11_o,
  output logic [DW-1:0]  data_12_o,
  output logic [DW-1:0]  data_20_o,
  output logic [DW-1:0]  data_21_o,
  output logic [DW-1:0]  data_22_o,
  output logic [XW-1:0]  win_x_o,
  output logic [YOW-1:0] win_y_o,
  output logic           eof_o
);

  // y reaches IMG_H during the bottom-pad flush
  localparam int YW = $clog2(IMG_H + 1);
  localparam logic [XW-1:0] XLAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] YLAST = YW'(IMG_H - 1);

  state_e        state, state_n;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          fend;

  logic          start;
  logic          adv, eol_cyc;
  logic [XW-1:0] ax;
  logic [YW-1:0] ay;
  logic [DW-1:0] pnew;
  logic [DW-1:0] lb0_q, lb1_q;
  logic [DW-1:0] col_top, col_mid;

  logic [2:0][2:0][DW-1:0] win_q, win_n, out_q;
  logic                    emit, last;
  logic [XW-1:0]           ex;
  logic [YOW-1:0]          ey;
  logic                    vld_q, eof_q;
  logic [XW-1:0]           x_q;
  logic [YOW-1:0]          y_q;

  assign start = sof_i && pix_valid_i;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (start) begin
      state_n = RUN;
    end else begin
      unique case (state)
        RUN:
          if (pix_valid_i && x == XLAST)
            state_n = EOL;
        EOL:
          state_n = (y == YLAST) ? FLUSH : RUN;
        FLUSH:
          if (fend) state_n = IDLE;
        default: ;
      endcase
    end
  end

  always_comb begin
    ready_o = 1'b0;
    unique case (state)
      IDLE, RUN: ready_o = 1'b1;
      default:   ready_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x    <= '0;
      y    <= '0;
      fend <= 1'b0;
    end else if (start) begin
      x    <= XW'(1);
      y    <= '0;
      fend <= 1'b0;
    end else begin
      unique case (state)
        RUN:
          if (pix_valid_i)
            x <= (x == XLAST) ? '0 : x + 1'b1;
        EOL: begin
          x <= '0;
          y <= (y == YLAST) ? YW'(IMG_H) : y + 1'b1;
        end
        FLUSH:
          if (fend) begin
            x    <= '0;
            y    <= '0;
            fend <= 1'b0;
          end else if (x == XLAST) begin
            x    <= '0;
            fend <= 1'b1;
          end else begin
            x <= x + 1'b1;
          end
        default: ;
      endcase
    end
  end

  // Column step source: real pixel, abort pixel or bottom pad
  always_comb begin
    adv     = 1'b0;
    eol_cyc = 1'b0;
    ax      = x;
    ay      = y;
    pnew    = '0;
    if (start) begin
      adv  = 1'b1;
      ax   = '0;
      ay   = '0;
      pnew = pix_data_i;
    end else begin
      unique case (state)
        RUN:
          if (pix_valid_i) begin
            adv  = 1'b1;
            pnew = pix_data_i;
          end
        EOL:   eol_cyc = 1'b1;
        FLUSH: begin
          adv     = !fend;
          eol_cyc = fend;
        end
        default: ;
      endcase
    end
  end

  line_buffer #(.W(IMG_W), .DW(DW)) u_lb0 (
    .clk   (clk),
    .we    (adv),
    .waddr (ax),
    .wdata (pnew),
    .raddr (ax),
    .rdata (lb0_q)
  );

  line_buffer #(.W(IMG_W), .DW(DW)) u_lb1 (
    .clk   (clk),
    .we    (adv),
    .waddr (ax),
    .wdata (col_mid),
    .raddr (ax),
    .rdata (lb1_q)
  );

  // Unwritten rows above the frame read as zero
  assign col_mid = (ay != '0)      ? lb0_q : '0;
  assign col_top = (ay > YW'(1))   ? lb1_q : '0;

  always_comb begin
    win_n = win_q;
    if (adv) begin
      for (int r = 0; r < 3; r++) begin
        win_n[r][0] = (ax == '0) ? '0 : win_q[r][1];
        win_n[r][1] = (ax == '0) ? '0 : win_q[r][2];
      end
      win_n[0][2] = col_top;
      win_n[1][2] = col_mid;
      win_n[2][2] = pnew;
    end else if (eol_cyc) begin
      for (int r = 0; r < 3; r++) begin
        win_n[r][0] = win_q[r][1];
        win_n[r][1] = win_q[r][2];
        win_n[r][2] = '0;
      end
    end
  end

  assign emit = (adv && ax != '0 && ay != '0) ||
                (eol_cyc && y != '0);
  assign last = eol_cyc && (state == FLUSH);
  assign ex   = adv ? ax - 1'b1 : XLAST;
  assign ey   = YOW'(ay - 1'b1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win_q <= '0;
      out_q <= '0;
      vld_q <= 1'b0;
      eof_q <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
    end else begin
      win_q <= win_n;
      vld_q <= emit;
      eof_q <= emit && last;
      if (emit) begin
        out_q <= win_n;
        x_q   <= ex;
        y_q   <= ey;
      end
    end
  end

  assign win_valid_o = vld_q;
  assign eof_o       = eof_q;
  assign win_x_o     = x_q;
  assign win_y_o     = y_q;
  assign data_00_o   = out_q[0][0];
  assign data_01_o   = out_q[0][1];
  assign data_02_o   = out_q[0][2];
  assign data_10_o   = out_q[1][0];
  assign data_11_o   = out_q[1][1];
  assign data_12_o   = out_q[1][2];
  assign data_20_o   = out_q[2][0];
  assign data_21_o   = out_q[2][1];
  assign data_22_o   = out_q[2][2];

endmodule

// File: tb/tb_window3x3_ctrl.sv
// Bench for window3x3_ctrl on a 4x3 frame, pix(x,y)=12'h0yx.
// Scoreboard of expected windows checked as the DUT emits them.
module tb_window3x3_ctrl;
  import win_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sof_i = 1'b0;
  logic        pix_valid_i = 1'b0;
  pixel_t      pix_data_i = '0;
  logic        ready_o, win_valid_o, eof_o;
  pixel_t      d00, d01, d02, d10, d11, d12, d20, d21, d22;
  logic [1:0]  win_x_o, win_y_o;

  window3x3_ctrl #(.IMG_W(4), .IMG_H(3), .DW(12)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sof_i       (sof_i),
    .pix_valid_i (pix_valid_i),
    .pix_data_i  (pix_data_i),
    .ready_o     (ready_o),
    .win_valid_o (win_valid_o),
    .data_00_o   (d00),
    .data_01_o   (d01),
    .data_02_o   (d02),
    .data_10_o   (d10),
    .data_11_o   (d11),
    .data_12_o   (d12),
    .data_20_o   (d20),
    .data_21_o   (d21),
    .data_22_o   (d22),
    .win_x_o     (win_x_o),
    .win_y_o     (win_y_o),
    .eof_o       (eof_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]       x;
    logic [3:0]       y;
    logic             eof;
    logic [8:0][11:0] t;
  } win_t;

  win_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   win_cnt = 0;
  logic [8:0][11:0] taps;

  assign taps = {d22, d21, d20, d12, d11, d10, d02, d01, d00};

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] pix(input int x, input int y);
    logic [3:0] xx, yy;
    xx = 4'(x);
    yy = 4'(y);
    return {4'h0, yy, xx};
  endfunction

  function automatic win_t mk_win(input int cx, input int cy);
    win_t w;
    int   px, py;
    w.x   = 4'(cx);
    w.y   = 4'(cy);
    w.eof = (cx == 3 && cy == 2);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        px = cx + c - 1;
        py = cy + r - 1;
        if (px >= 0 && px < 4 && py >= 0 && py < 3)
          w.t[r*3+c] = pix(px, py);
        else
          w.t[r*3+c] = 12'h000;
      end
    return w;
  endfunction

  // Windows that become due once pixel (x,y) is taken
  task automatic model_accept(input int x, input int y);
    if (x >= 1 && y >= 1) exp_q.push_back(mk_win(x - 1, y - 1));
    if (x == 3 && y >= 1) exp_q.push_back(mk_win(3, y - 1));
    if (x == 3 && y == 2)
      for (int cx = 0; cx < 4; cx++) exp_q.push_back(mk_win(cx, 2));
  endtask

  always @(negedge clk) begin
    win_t e;
    if (reset_n && win_valid_o) begin
      win_cnt++;
      if (exp_q.size() == 0) begin
        chk("extra_win", 32'(win_valid_o), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("win_x", 32'(win_x_o), 32'(e.x));
        chk("win_y", 32'(win_y_o), 32'(e.y));
        chk("eof", 32'(eof_o), 32'(e.eof));
        for (int k = 0; k < 9; k++)
          chk($sformatf("tap%0d", k), 32'(taps[k]), 32'(e.t[k]));
      end
    end
  end

  // Send the first n pixels of a frame, with optional random gaps
  task automatic run_frame(input int gap_pct, input int n,
                           output int stalls);
    int   i   = 0;
    int   cyc = 0;
    logic v, rdy;
    stalls = 0;
    while (i < n && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      v = !(gap_pct > 0 && int'($urandom_range(99, 0)) < gap_pct);
      pix_valid_i = v;
      sof_i       = v && (i == 0);
      pix_data_i  = pix(i % 4, i / 4);
      #1 rdy = ready_o;
      @(posedge clk);
      if (v && rdy) begin
        model_accept(i % 4, i / 4);
        i++;
      end else if (v) begin
        stalls++;
      end
    end
    chk("accepted", 32'(i), 32'(n));
    @(negedge clk);
    pix_valid_i = 1'b0;
    sof_i       = 1'b0;
  endtask

  task automatic wait_tail(output int cnt);
    cnt = 0;
    while (!ready_o && cnt < 50) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic frame_done(input int wins);
    repeat (3) @(negedge clk);
    chk("win_cnt", 32'(win_cnt), 32'(wins));
    chk("sb_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog");
    $fatal(1, "timeout");
  end

  initial begin
    int st, tl;
    @(negedge clk);
    chk("rst_vld", 32'(win_valid_o), 32'd0);
    chk("rst_eof", 32'(eof_o), 32'd0);
    chk("rst_rdy", 32'(ready_o), 32'd1);
    chk("rst_d11", 32'(d11), 32'd0);
    chk("rst_x", 32'(win_x_o), 32'd0);
    #2 reset_n = 1'b1;

    // Reset in the middle of a frame
    win_cnt = 0;
    run_frame(0, 7, st);
    @(negedge clk);
    #2 reset_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("mrst_vld", 32'(win_valid_o), 32'd0);
    chk("mrst_eof", 32'(eof_o), 32'd0);
    chk("mrst_rdy", 32'(ready_o), 32'd1);
    #2 reset_n = 1'b1;

    // Continuous frame with valid held high
    win_cnt = 0;
    run_frame(0, 12, st);
    chk("run_stalls", 32'(st), 32'd2);
    wait_tail(tl);
    chk("tail_low", 32'(tl), 32'd6);
    frame_done(12);

    // Random source gaps
    win_cnt = 0;
    run_frame(30, 12, st);
    wait_tail(tl);
    chk("gap_tail", 32'(tl), 32'd6);
    frame_done(12);

    // Abort with sof at pixel (2,1)
    win_cnt = 0;
    run_frame(0, 6, st);
    run_frame(0, 12, st);
    wait_tail(tl);
    chk("abort_tail", 32'(tl), 32'd6);
    frame_done(13);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
